mem_handle_server: RTL
======================

# mem_handle_server

Services single-word requests issued on a memory handle (e.g. by the region-zeroing FSM and other region walkers) against one synchronous on-chip SRAM bank. Sits directly downstream of the handle producers. Accepts one request at a time, bounds-checks the pointer against the handle's region, drives the SRAM port, returns read data, and raises `done` for the level handshake the producers poll (`done && avail`).

## Interface
- `ADDR_W`, 16: SRAM word-address width; SRAM address = `ptr[ADDR_W-1:0]`.
- `DATA_W`, 32: word width.
- `READ_LATENCY`, 1: SRAM cycles from `sram_en` to valid `sram_rdata`; legal range 1..4.

- `clk`  in  1  clock
- `rst_l`  in  1  asynchronous active-low reset
- `avail`  in  1  request valid; held by producer until it sees `done`
- `w_en`  in  1  write request
- `r_en`  in  1  read request
- `ptr`  in  32  word pointer
- `data_store`  in  DATA_W  write data
- `region_begin`, `region_end`  in  32 each  inclusive legal pointer bounds
- `done`  out  1  request complete; held until `avail` drops
- `data_load`  out  DATA_W  read data, valid while `done` and last op was a read
- `err`  out  1  last request out of bounds or had neither enable; valid with `done`
- `sram_en`  out  1  SRAM access strobe
- `sram_we`  out  1  SRAM write enable (qualified by `sram_en`)
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_rdata`  in  DATA_W  SRAM read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `avail`, latch `ptr`, `data_store`, op type, bounds result; go ISSUE. Else stay.
- Op decode: `w_en` wins over `r_en` (write performed). Neither set -> `err`=1, no SRAM access.
- Bounds: legal iff `region_begin <= ptr <= region_end` (unsigned 32-bit). Illegal -> `err`=1, no SRAM access, `data_load` unchanged.
- ISSUE (one cycle): legal op -> `sram_en`=1, `sram_we`=write, addr/wdata from latches. Write or error -> DONE. Read -> WAIT with latency counter loaded to READ_LATENCY-1.
- WAIT: decrement counter; when counter is 0 capture `sram_rdata` into `data_load`, go DONE.
- DONE: `done`=1. Leave to IDLE on first cycle `avail`=0 is sampled (`done` falls next cycle).
- Producer dropping `avail` before `done`: transaction still completes (no abort); in DONE `done` pulses exactly one cycle, then IDLE.
- `err` cleared on each new acceptance; `data_load` only changes on a legal read.
- Reset (any state, including mid-read): state IDLE; `done`, `err`, `sram_en`, `sram_we` = 0; `sram_addr`, `sram_wdata`, `data_load` = 0. An in-flight read is discarded.

## Timing
- Cycle 0 = first cycle `avail`=1 sampled in IDLE.
- All outputs registered; no combinational path input -> output.
- Write/error: `sram_en` high cycle 1 (write only); `done` high from cycle 2.
- Read: `sram_en` cycle 1; `sram_rdata` sampled at end of cycle 1+READ_LATENCY; `done` and `data_load` valid from cycle 2+READ_LATENCY.
- `done` held while `avail`=1; falls one cycle after `avail` sampled 0; earliest next acceptance is the cycle after `done` falls.
- Back-to-back with a producer that drops `avail` one cycle after seeing `done` and re-raises one cycle later: one write per 4 cycles.

## Structure
- Shared package `mem_pkg`: state enum `srv_state_t`, `DATA_W`/`ADDR_W` defaults, op-type enum (`OP_RD`, `OP_WR`, `OP_NONE`).
- Single module; no sub-module. Bench supplies behavioural `sram_model` honouring READ_LATENCY.

## Test plan
- Region 0x10..0x13, ZeroRegion-style producer writes 0 to each -> four `sram_en`/`sram_we` pulses at addr 0x10..0x13, `done` from cycle 2 each, no `err`.
- Preload addr 0x20=0xDEADBEEF, read ptr 0x20, READ_LATENCY=3 -> `done` and `data_load`=0xDEADBEEF at cycle 5.
- Write ptr 0x30 with region 0x10..0x2F -> no `sram_en`, `done` cycle 2, `err`=1; following legal read clears `err`.
- `w_en`=`r_en`=1, ptr 0x11, data 0x55 -> write of 0x55 performed, `data_load` unchanged.
- `avail` dropped in cycle 1 of a read -> read completes, `done` high exactly one cycle, back to IDLE.
- `rst_l` asserted in WAIT -> all outputs 0 immediately, no `done`; next request after release serviced normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory handle server.
//   srv_state_t : server FSM states
//   op_t        : decoded request type (write wins over read)
//   decode_op   : maps the w_en/r_en pair onto op_t
package mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;
    // Latency counter width; covers READ_LATENCY-1 for latencies 1..4.
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } srv_state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_NONE
    } op_t;

    function automatic op_t decode_op(input logic w, input logic r);
        if (w)      return OP_WR;
        else if (r) return OP_RD;
        else        return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_handle_server.sv
// mem_handle_server: services one single-word handle request at a time
// against a synchronous SRAM bank, with region bounds checking.
//   clk, rst_l              : clock, async active-low reset
//   avail/w_en/r_en/ptr/data_store/region_begin/region_end : request in
//   done/data_load/err      : level-handshake completion, held until avail drops
//   sram_en/we/addr/wdata   : registered SRAM port, sram_rdata returns
//                             READ_LATENCY cycles after sram_en
// Every output is a flop; nothing combinational reaches an output.
module mem_handle_server
    import mem_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              avail,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [31:0]       ptr,
    input  logic [DATA_W-1:0] data_store,
    input  logic [31:0]       region_begin,
    input  logic [31:0]       region_end,
    output logic              done,
    output logic [DATA_W-1:0] data_load,
    output logic              err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    srv_state_t        state_q, state_d;
    op_t               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_load_q, data_load_d;
    logic              sram_en_q, sram_en_d;
    logic              sram_we_q, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;

    op_t  req_op;
    logic in_bounds;
    logic req_bad;

    assign req_op    = decode_op(w_en, r_en);
    assign in_bounds = (ptr >= region_begin) && (ptr <= region_end);
    assign req_bad   = !in_bounds || (req_op == OP_NONE);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        err_d        = err_q;
        data_load_d  = data_load_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    // Rejected requests are carried as OP_NONE so ISSUE
                    // routes them straight to DONE without touching SRAM.
                    err_d   = req_bad;
                    op_d    = req_bad ? OP_NONE : req_op;
                    state_d = S_ISSUE;
                    if (!req_bad) begin
                        sram_en_d    = 1'b1;
                        sram_we_d    = (req_op == OP_WR);
                        sram_addr_d  = ptr[ADDR_W-1:0];
                        sram_wdata_d = data_store;
                    end
                end
            end
            S_ISSUE: begin
                if (op_q == OP_RD) begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = S_WAIT;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    data_load_d = sram_rdata;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                // A producer that already dropped avail still gets one
                // cycle of done before the server returns to IDLE.
                if (!avail) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NONE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            data_load_q  <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            data_load_q  <= data_load_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign data_load  = data_load_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule
